// File: rtl/blit_pkg.sv
// Shared definitions for the text-blit sequencer: FSM state encoding and
// default widths.
package blit_pkg;

   localparam int ADDR_W_DEF  = 26;
   localparam int LEN_W_DEF   = 12;
   localparam int COORD_W_DEF = 16;

   localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EMIT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/blit_text_unpack.sv
// Holds the most recently fetched string word and the lane pointer, and
// presents the current character plus a last-lane flag.
module blit_text_unpack
   import blit_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load_i,
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic        adv_i,
   output logic [7:0]  char_o,
   output logic        last_o
);

   logic [31:0] word_q;
   logic [1:0]  lane_q;

   // NOTE: sequential state is assigned with <= so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         word_q <= '0;
         lane_q <= '0;
      end else if (load_i) begin
         word_q <= word_i;
         lane_q <= lane_i;
      end else if (adv_i) begin
         lane_q <= lane_q + 2'd1;
      end
   end

   // Little-endian lanes: lane 0 is bits [7:0].
   assign char_o = word_q[{lane_q, 3'b000} +: 8];
   assign last_o = (lane_q == 2'd3);

endmodule

// File: rtl/blit_text_seq.sv
// Text-blit sequencer: fetches a string word by word and issues one p1 beat
// per character. Define BLIT_TEXT_NEWLINE_EN to turn 0x0A into a line break.
module blit_text_seq
   import blit_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int COORD_W = COORD_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ADDR_W-1:0]  cmd_str_addr,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [ADDR_W-1:0]  cmd_font_addr,
   input  logic [7:0]         cmd_font_bpc,
   input  logic [7:0]         cmd_char_w,
   input  logic [7:0]         cmd_char_h,
   input  logic [COORD_W-1:0] cmd_x,
   input  logic [COORD_W-1:0] cmd_y,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [31:0]        mem_rdata,
   input  logic               stall,
   output logic               p1_valid,
   output logic [ADDR_W-1:0]  p1_src_addr,
   output logic [7:0]         p1_char,
   output logic [7:0]         p1_font_bpc,
   output logic               p1_textmode,
   output logic [COORD_W-1:0] p1_dest_x,
   output logic [COORD_W-1:0] p1_dest_y,
   output logic               busy,
   output logic               done
);

`ifdef BLIT_TEXT_NEWLINE_EN
   localparam bit NL_EN = 1'b1;
`else
   localparam bit NL_EN = 1'b0;
`endif

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d, font_q, font_d;
   logic [7:0]         bpc_q, bpc_d, cw_q, cw_d, ch_q, ch_d;
   logic [COORD_W-1:0] x0_q, x0_d, x_q, x_d, y_q, y_d;
   logic [LEN_W-1:0]   rem_q, rem_d;

   logic [7:0] cur_char;
   logic       last_in_word, load_word, is_nl, beat, advance;

   assign is_nl     = NL_EN && (cur_char == NEWLINE_CHAR);
   assign load_word = (state_q == ST_FETCH) && mem_ack;
   assign beat      = (state_q == ST_EMIT) && !is_nl;
   // A newline consumes its cycle without waiting on the downstream stall.
   assign advance   = (state_q == ST_EMIT) && (is_nl || !stall);

   blit_text_unpack u_unpack (
      .clock  (clock),
      .reset  (reset),
      .load_i (load_word),
      .word_i (mem_rdata),
      .lane_i (ptr_q[1:0]),
      .adv_i  (advance),
      .char_o (cur_char),
      .last_o (last_in_word)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         font_q  <= '0;
         bpc_q   <= '0;
         cw_q    <= '0;
         ch_q    <= '0;
         x0_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         font_q  <= font_d;
         bpc_q   <= bpc_d;
         cw_q    <= cw_d;
         ch_q    <= ch_d;
         x0_q    <= x0_d;
         x_q     <= x_d;
         y_q     <= y_d;
         rem_q   <= rem_d;
      end
   end

   // NOTE: every next-state value defaults to its register first, so no
   // path through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      font_d  = font_q;
      bpc_d   = bpc_q;
      cw_d    = cw_q;
      ch_d    = ch_q;
      x0_d    = x0_q;
      x_d     = x_q;
      y_d     = y_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               ptr_d   = cmd_str_addr;
               font_d  = cmd_font_addr;
               bpc_d   = cmd_font_bpc;
               cw_d    = cmd_char_w;
               ch_d    = cmd_char_h;
               x0_d    = cmd_x;
               x_d     = cmd_x;
               y_d     = cmd_y;
               rem_d   = cmd_len;
               state_d = (cmd_len == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (mem_ack) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (advance) begin
               rem_d = rem_q - 1'b1;
               ptr_d = ptr_q + 1'b1;
               if (is_nl) begin
                  x_d = x0_q;
                  y_d = y_q + COORD_W'(ch_q);
               end else begin
                  x_d = x_q + COORD_W'(cw_q);
               end
               if (rem_q == LEN_W'(1))  state_d = ST_DONE;
               else if (last_in_word)   state_d = ST_FETCH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign mem_req     = (state_q == ST_FETCH);
   assign mem_addr    = {ptr_q[ADDR_W-1:2], 2'b00};
   assign p1_valid    = beat;
   assign p1_textmode = beat;
   assign p1_src_addr = font_q;
   assign p1_char     = cur_char;
   assign p1_font_bpc = bpc_q;
   assign p1_dest_x   = x_q;
   assign p1_dest_y   = y_q;

endmodule

// File: tb/tb_blit_text_seq.sv
// Directed self-checking bench for blit_text_seq; memory returns
// byte(addr) = addr[7:0] ^ 0x40 with a programmable ack latency.
module tb_blit_text_seq;

   localparam int ADDR_W  = 26;
   localparam int LEN_W   = 12;
   localparam int COORD_W = 16;

   logic               clock, reset;
   logic               cmd_valid, cmd_ready;
   logic [ADDR_W-1:0]  cmd_str_addr, cmd_font_addr;
   logic [LEN_W-1:0]   cmd_len;
   logic [7:0]         cmd_font_bpc, cmd_char_w, cmd_char_h;
   logic [COORD_W-1:0] cmd_x, cmd_y;
   logic               mem_req, mem_ack;
   logic [ADDR_W-1:0]  mem_addr;
   logic [31:0]        mem_rdata;
   logic               stall, p1_valid, p1_textmode, busy, done;
   logic [ADDR_W-1:0]  p1_src_addr;
   logic [7:0]         p1_char, p1_font_bpc;
   logic [COORD_W-1:0] p1_dest_x, p1_dest_y;

   int checks   = 0;
   int failures = 0;
   int mem_lat  = 0;
   int wait_cnt = 0;
   int n_fetch  = 0;
   int f0;

   blit_text_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .COORD_W(COORD_W)) dut (
      .clock         (clock),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_str_addr  (cmd_str_addr),
      .cmd_len       (cmd_len),
      .cmd_font_addr (cmd_font_addr),
      .cmd_font_bpc  (cmd_font_bpc),
      .cmd_char_w    (cmd_char_w),
      .cmd_char_h    (cmd_char_h),
      .cmd_x         (cmd_x),
      .cmd_y         (cmd_y),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .stall         (stall),
      .p1_valid      (p1_valid),
      .p1_src_addr   (p1_src_addr),
      .p1_char       (p1_char),
      .p1_font_bpc   (p1_font_bpc),
      .p1_textmode   (p1_textmode),
      .p1_dest_x     (p1_dest_x),
      .p1_dest_y     (p1_dest_y),
      .busy          (busy),
      .done          (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
      logic [31:0] w;
      logic [7:0]  base;
      base = {a[7:2], 2'b00};
      for (int k = 0; k < 4; k++) w[8*k +: 8] = (base + 8'(k)) ^ 8'h40;
      return w;
   endfunction

   // Memory responder: decides ack for the coming edge on each falling edge.
   always @(negedge clock) begin
      if (mem_req && wait_cnt >= mem_lat) begin
         mem_ack   = 1'b1;
         mem_rdata = word_at(mem_addr);
         n_fetch++;
         wait_cnt  = 0;
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = 32'hDEAD_BEEF;
         wait_cnt  = mem_req ? wait_cnt + 1 : 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [ADDR_W-1:0] sa, input logic [LEN_W-1:0] len,
                        input logic [7:0] cw, input logic [7:0] ch,
                        input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      @(negedge clock);
      cmd_str_addr = sa;
      cmd_len      = len;
      cmd_char_w   = cw;
      cmd_char_h   = ch;
      cmd_x        = x;
      cmd_y        = y;
      cmd_valid    = 1'b1;
      @(negedge clock);
      cmd_valid    = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [7:0] c,
                       input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      @(negedge clock);
      chk({tag, "_valid"}, 32'(p1_valid), 32'd1);
      chk({tag, "_char"},  32'(p1_char),  32'(c));
      chk({tag, "_x"},     32'(p1_dest_x), 32'(x));
      chk({tag, "_y"},     32'(p1_dest_y), 32'(y));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      cmd_valid     = 1'b0;
      cmd_str_addr  = '0;
      cmd_len       = '0;
      cmd_font_addr = 26'h0003000;
      cmd_font_bpc  = 8'd16;
      cmd_char_w    = '0;
      cmd_char_h    = '0;
      cmd_x         = '0;
      cmd_y         = '0;
      stall         = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset state
      @(negedge clock);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_req",   32'(mem_req),   32'd0);
      chk("rst_valid", 32'(p1_valid),  32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_addr",  32'(mem_addr),  32'd0);
      chk("rst_char",  32'(p1_char),   32'd0);
      chk("rst_x",     32'(p1_dest_x), 32'd0);

      // Aligned 4-char string, single-cycle memory
      f0 = n_fetch;
      issue(26'h100, 12'd4, 8'd8, 8'd0, 16'd10, 16'd20);
      chk("t1_req",   32'(mem_req),   32'd1);
      chk("t1_addr",  32'(mem_addr),  32'h100);
      chk("t1_busy",  32'(busy),      32'd1);
      chk("t1_ready", 32'(cmd_ready), 32'd0);
      beat("t1_b0", 8'h40, 16'd10, 16'd20);
      chk("t1_src",  32'(p1_src_addr), 32'h3000);
      chk("t1_bpc",  32'(p1_font_bpc), 32'd16);
      chk("t1_tm",   32'(p1_textmode), 32'd1);
      beat("t1_b1", 8'h41, 16'd18, 16'd20);
      beat("t1_b2", 8'h42, 16'd26, 16'd20);
      beat("t1_b3", 8'h43, 16'd34, 16'd20);
      @(negedge clock);
      chk("t1_done",   32'(done),     32'd1);
      chk("t1_dvalid", 32'(p1_valid), 32'd0);
      chk("t1_nfetch", 32'(n_fetch - f0), 32'd1);
      @(negedge clock);
      chk("t1_done_off", 32'(done),      32'd0);
      chk("t1_ready_bk", 32'(cmd_ready), 32'd1);
      chk("t1_busy_off", 32'(busy),      32'd0);

      // Unaligned start crossing a word boundary
      f0 = n_fetch;
      issue(26'h103, 12'd3, 8'd1, 8'd0, 16'd0, 16'd0);
      chk("t2_addr0", 32'(mem_addr), 32'h100);
      beat("t2_b0", 8'h43, 16'd0, 16'd0);
      @(negedge clock);
      chk("t2_req1",  32'(mem_req),  32'd1);
      chk("t2_addr1", 32'(mem_addr), 32'h104);
      chk("t2_gap",   32'(p1_valid), 32'd0);
      beat("t2_b1", 8'h44, 16'd1, 16'd0);
      beat("t2_b2", 8'h45, 16'd2, 16'd0);
      @(negedge clock);
      chk("t2_done",   32'(done), 32'd1);
      chk("t2_nfetch", 32'(n_fetch - f0), 32'd2);

      // Zero-length command
      f0 = n_fetch;
      issue(26'h100, 12'd0, 8'd8, 8'd0, 16'd0, 16'd0);
      chk("t3_done", 32'(done),    32'd1);
      chk("t3_busy", 32'(busy),    32'd1);
      chk("t3_req",  32'(mem_req), 32'd0);
      @(negedge clock);
      chk("t3_done_off", 32'(done), 32'd0);
      chk("t3_busy_off", 32'(busy), 32'd0);
      chk("t3_nfetch",   32'(n_fetch - f0), 32'd0);

      // Slow memory plus a 5-cycle stall on the second beat
      mem_lat = 2;
      issue(26'h100, 12'd4, 8'd3, 8'd0, 16'd100, 16'd7);
      @(negedge clock);
      chk("t4_hold_req",  32'(mem_req),  32'd1);
      chk("t4_hold_addr", 32'(mem_addr), 32'h100);
      @(negedge clock);
      beat("t4_b0", 8'h40, 16'd100, 16'd7);
      beat("t4_b1", 8'h41, 16'd103, 16'd7);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         beat("t4_stall", 8'h41, 16'd103, 16'd7);
         if (i == 4) stall = 1'b0;
      end
      beat("t4_b2", 8'h42, 16'd106, 16'd7);
      beat("t4_b3", 8'h43, 16'd109, 16'd7);
      @(negedge clock);
      chk("t4_done", 32'(done), 32'd1);
      mem_lat = 0;

      // Destination x wraps
      issue(26'h200, 12'd2, 8'd8, 8'd0, 16'hFFF8, 16'd3);
      beat("t5_b0", 8'h40, 16'hFFF8, 16'd3);
      beat("t5_b1", 8'h41, 16'h0000, 16'd3);
      @(negedge clock);
      chk("t5_done", 32'(done), 32'd1);

      // Asynchronous reset during EMIT, then a fresh command
      issue(26'h100, 12'd4, 8'd8, 8'd0, 16'd0, 16'd0);
      @(negedge clock);
      chk("t6_emit", 32'(p1_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t6_valid", 32'(p1_valid),  32'd0);
      chk("t6_req",   32'(mem_req),   32'd0);
      chk("t6_busy",  32'(busy),      32'd0);
      chk("t6_ready", 32'(cmd_ready), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      issue(26'h104, 12'd1, 8'd8, 8'd0, 16'd7, 16'd9);
      chk("t6_addr", 32'(mem_addr), 32'h104);
      beat("t6_b0", 8'h44, 16'd7, 16'd9);
      @(negedge clock);
      chk("t6_done", 32'(done), 32'd1);

      // String containing 0x0A (bytes 0x09,0x0A,0x0B at 0x49..0x4B)
      issue(26'h049, 12'd3, 8'd8, 8'd12, 16'd5, 16'd0);
      chk("t7_addr", 32'(mem_addr), 32'h48);
      beat("t7_b0", 8'h09, 16'd5, 16'd0);
`ifdef BLIT_TEXT_NEWLINE_EN
      @(negedge clock);
      chk("t7_nl_valid", 32'(p1_valid), 32'd0);
      beat("t7_b1", 8'h0B, 16'd5, 16'd12);
`else
      beat("t7_nl", 8'h0A, 16'd13, 16'd0);
      beat("t7_b1", 8'h0B, 16'd21, 16'd0);
`endif
      @(negedge clock);
      chk("t7_done", 32'(done), 32'd1);

      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
